// File: rtl/health_ctrl.sv
// health_ctrl: per-player health FSM with damage, heals, post-hit invulnerability and a blinking top box.
module health_ctrl #(
   parameter int MAX_HEALTH    = 5,
   parameter int INVULN_FRAMES = 30
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       round_start,
   input  logic       hit,
   input  logic [1:0] hit_dmg,
   input  logic       heal,
   output logic [2:0] health_count,
   output logic [4:0] health_mask,
   output logic       invuln,
   output logic       dead
);
   typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;
   localparam logic [2:0] MAXH = 3'(MAX_HEALTH);
   localparam logic [4:0] FULL = 5'((6'd1 << MAXH) - 6'd1);
   state_t     state, state_n;
   logic       sync1, sync2, sync3, tick;
   logic [2:0] health_n, blink_cnt, blink_n, healed;
   logic [7:0] inv_timer, timer_n;
   logic [3:0] diff;
   logic [4:0] therm, mask_n;
   assign tick   = sync2 & ~sync3;
   assign diff   = {1'b0, health_count} - {2'b0, hit_dmg};
   assign healed = health_count >= MAXH ? MAXH : health_count + 3'd1;
   always_comb begin
      state_n  = state;
      health_n = health_count;
      timer_n  = inv_timer;
      blink_n  = tick ? blink_cnt + 3'd1 : blink_cnt;
      if (round_start) begin
         state_n  = ALIVE;
         health_n = MAXH;
         timer_n  = 8'd0;
         blink_n  = 3'd0;
      end else if (state == ALIVE) begin
         if (hit) begin
            // a zero or lethal hit never wraps: the 4-bit difference exposes underflow
            if (hit_dmg != 2'd0 && (diff[3] || diff == 4'd0)) begin
               health_n = 3'd0;
               state_n  = DEAD;
            end else if (hit_dmg != 2'd0) begin
               health_n = diff[2:0];
               state_n  = INVULN;
               timer_n  = 8'(INVULN_FRAMES);
               blink_n  = 3'd0;
            end
         end else if (heal) begin
            health_n = healed;
         end
      end else if (state == INVULN) begin
         if (tick) begin
            timer_n = inv_timer - 8'd1;
            state_n = inv_timer == 8'd1 ? ALIVE : INVULN;
         end
         if (heal) health_n = healed;
      end
      therm  = 5'((6'd1 << health_n) - 6'd1);
      mask_n = (state_n == INVULN && blink_n[2]) ? therm & ~(5'd1 << (health_n - 3'd1)) : therm;
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         {sync1, sync2, sync3} <= 3'b000;
         state        <= ALIVE;
         health_count <= MAXH;
         inv_timer    <= 8'd0;
         blink_cnt    <= 3'd0;
         health_mask  <= FULL;
         invuln       <= 1'b0;
         dead         <= 1'b0;
      end else begin
         {sync1, sync2, sync3} <= {frame_clk, sync1, sync2};
         state        <= state_n;
         health_count <= health_n;
         inv_timer    <= timer_n;
         blink_cnt    <= blink_n;
         health_mask  <= mask_n;
         invuln       <= state_n == INVULN;
         dead         <= state_n == DEAD;
      end
   end
endmodule

// File: tb/tb_health_ctrl.sv
// tb_health_ctrl: directed stimulus on two instances (4- and 30-frame invulnerability) checked against a behavioural model.
module tb_health_ctrl;
   logic       Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, round_start = 1'b0, hit = 1'b0, heal = 1'b0;
   logic [1:0] hit_dmg = 2'd0;
   logic [2:0] hc [2];
   logic [4:0] mask [2];
   logic       inv [2], dd [2];
   int tests = 0, fails = 0;
   int mh [2], mst [2], mrem [2], mblk [2];
   int frames_len [2] = '{4, 30};
   int tickq [$];
   int edge_n = 0;
   logic prev_fc = 1'b0;
   always #5 Clk = ~Clk;
   health_ctrl #(.MAX_HEALTH(5), .INVULN_FRAMES(4)) dut_a (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .round_start(round_start), .hit(hit),
      .hit_dmg(hit_dmg), .heal(heal), .health_count(hc[0]), .health_mask(mask[0]), .invuln(inv[0]), .dead(dd[0]));
   health_ctrl #(.MAX_HEALTH(5), .INVULN_FRAMES(30)) dut_b (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .round_start(round_start), .hit(hit),
      .hit_dmg(hit_dmg), .heal(heal), .health_count(hc[1]), .health_mask(mask[1]), .invuln(inv[1]), .dead(dd[1]));
   // model states: 0 = alive, 1 = invulnerable, 2 = dead
   task automatic model_reset(input int k);
      mh[k] = 5; mst[k] = 0; mrem[k] = 0; mblk[k] = 0;
   endtask
   function automatic int exp_mask(input int k);
      int m = (1 << mh[k]) - 1;
      if (mst[k] == 1 && mblk[k] >= 4) m = m & ~(1 << (mh[k] - 1));
      return m;
   endfunction
   task automatic model_edge();
      bit t;
      edge_n++;
      t = tickq.size() > 0 && tickq[0] == edge_n;
      if (t) void'(tickq.pop_front());
      if (Reset) begin
         tickq.delete();
         prev_fc = 1'b0;
         for (int k = 0; k < 2; k++) model_reset(k);
      end else begin
         // a frame_clk rise sampled at edge n takes effect at edge n+2
         if (frame_clk && !prev_fc) tickq.push_back(edge_n + 2);
         prev_fc = frame_clk;
         for (int k = 0; k < 2; k++) begin
            int nb = t ? (mblk[k] + 1) % 8 : mblk[k];
            int st = mst[k];
            if (round_start) begin
               model_reset(k);
               nb = 0;
            end else if (st == 0) begin
               if (hit && hit_dmg > 0) begin
                  if (int'(hit_dmg) >= mh[k]) begin mh[k] = 0; mst[k] = 2; end
                  else begin mh[k] -= int'(hit_dmg); mst[k] = 1; mrem[k] = frames_len[k]; nb = 0; end
               end else if (!hit && heal) mh[k] = mh[k] < 5 ? mh[k] + 1 : 5;
            end else if (st == 1) begin
               if (t) begin mrem[k]--; if (mrem[k] == 0) mst[k] = 0; end
               if (heal) mh[k] = mh[k] < 5 ? mh[k] + 1 : 5;
            end
            mblk[k] = nb;
         end
      end
   endtask
   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask
   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("model_hc[%0d]", k), int'(hc[k]), mh[k]);
         chk($sformatf("model_mask[%0d]", k), int'(mask[k]), exp_mask(k));
         chk($sformatf("model_inv[%0d]", k), int'(inv[k]), int'(mst[k] == 1));
         chk($sformatf("model_dead[%0d]", k), int'(dd[k]), int'(mst[k] == 2));
      end
   endtask
   task automatic cyc(input logic r, input logic rs, input logic h, input logic [1:0] d, input logic he);
      Reset = r; round_start = rs; hit = h; hit_dmg = d; heal = he;
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
      Reset = 1'b0; round_start = 1'b0; hit = 1'b0; hit_dmg = 2'd0; heal = 1'b0;
      check_all();
   endtask
   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
   endtask
   task automatic frames(input int n);
      repeat (n) begin
         frame_clk = 1'b1; idle(3);
         frame_clk = 1'b0; idle(3);
      end
   endtask
   initial begin
      for (int k = 0; k < 2; k++) model_reset(k);
      @(negedge Clk);
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      idle(10);
      chk("reset_hc", int'(hc[0]), 5);
      chk("reset_mask", int'(mask[0]), 5'b11111);
      chk("reset_inv", int'(inv[0]), 0);
      chk("reset_dead", int'(dd[0]), 0);
      cyc(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
      chk("hit2_hc", int'(hc[0]), 3);
      chk("hit2_inv", int'(inv[0]), 1);
      frames(3);
      chk("tick3_mask", int'(mask[0]), 5'b00111);
      chk("tick3_inv", int'(inv[0]), 1);
      cyc(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
      chk("inv_hit_ignored", int'(hc[0]), 3);
      frames(1);
      chk("tick4_alive", int'(inv[0]), 0);
      chk("tick4_b_still_inv", int'(inv[1]), 1);
      cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
      chk("blink_t0", int'(mask[1]), 5'b01111);
      frames(3);
      chk("blink_t3", int'(mask[1]), 5'b01111);
      frames(1);
      chk("blink_t4", int'(mask[1]), 5'b00111);
      frames(3);
      chk("blink_t7", int'(mask[1]), 5'b00111);
      frames(1);
      chk("blink_t8", int'(mask[1]), 5'b01111);
      cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
      chk("heal_sat_alive", int'(hc[0]), 5);
      cyc(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
      chk("dmg0_hc", int'(hc[0]), 5);
      chk("dmg0_inv", int'(inv[0]), 0);
      cyc(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
      frames(30);
      chk("b_exit_after_30", int'(inv[1]), 0);
      chk("b_hc_3", int'(hc[1]), 3);
      cyc(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
      frames(4);
      chk("a_hc_1", int'(hc[0]), 1);
      cyc(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
      chk("kill_hc", int'(hc[0]), 0);
      chk("kill_dead", int'(dd[0]), 1);
      chk("kill_mask", int'(mask[0]), 0);
      cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
      frames(2);
      chk("dead_ignores_hc", int'(hc[0]), 0);
      chk("dead_ignores_dead", int'(dd[0]), 1);
      cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      chk("round_hc", int'(hc[0]), 5);
      chk("round_dead", int'(dd[0]), 0);
      cyc(1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
      chk("hit_heal_hc", int'(hc[0]), 4);
      chk("hit_heal_inv", int'(inv[0]), 1);
      cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
      chk("inv_heal_hc", int'(hc[0]), 5);
      chk("inv_heal_inv", int'(inv[0]), 1);
      cyc(1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
      chk("inv_hit_heal_hc", int'(hc[0]), 5);
      frame_clk = 1'b1;
      idle(1);
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      chk("midinv_reset_inv", int'(inv[0]), 0);
      chk("midinv_reset_hc", int'(hc[0]), 5);
      chk("midinv_reset_mask", int'(mask[0]), 5'b11111);
      frame_clk = 1'b0;
      idle(5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
